// File: rtl/tea_encryptor_iter_pkg.sv
// Shared TEA types, constants and the round mix function.
// The decryptor array imports this package as well.
package tea_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t k0;
        word_t k1;
        word_t k2;
        word_t k3;
    } key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam word_t TEA_DELTA          = 32'h9E3779B9;
    localparam int    TEA_ROUNDS_DEFAULT = 32;

    function automatic word_t tea_mix(word_t x, word_t sum, word_t ka, word_t kb);
        return ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_encryptor_iter_if.sv
// Plaintext/key input handshake and ciphertext output handshake.
interface tea_encryptor_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [63:0]  inBlock64;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  outBlock64;

    modport master (
        output in_valid, inBlock64, key, out_ready,
        input  in_ready, out_valid, outBlock64
    );

    modport slave (
        input  in_valid, inBlock64, key, out_ready,
        output in_ready, out_valid, outBlock64
    );

endinterface

// File: rtl/tea_encryptor_iter_round.sv
// One combinational TEA encrypt cycle: advances sum, then v0, then v1
// (v1 uses the freshly updated v0).
module tea_enc_round
    import tea_pkg::*;
#(
    parameter word_t DELTA = TEA_DELTA
) (
    input  word_t v0_i,
    input  word_t v1_i,
    input  word_t sum_i,
    input  key_t  key_i,
    output word_t v0_o,
    output word_t v1_o,
    output word_t sum_o
);

    assign sum_o = sum_i + DELTA;
    assign v0_o  = v0_i + tea_mix(v1_i, sum_o, key_i.k0, key_i.k1);
    assign v1_o  = v1_i + tea_mix(v0_o, sum_o, key_i.k2, key_i.k3);

endmodule

// File: rtl/tea_encryptor_iter.sv
// Iterative TEA block encryptor, one cycle per clock.
// Define TEA_ENC_UNROLL2_EN to chain two round instances per clock.
module tea_encryptor_iter
    import tea_pkg::*;
#(
    parameter int    ROUNDS = TEA_ROUNDS_DEFAULT,
    parameter word_t DELTA  = TEA_DELTA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    tea_encryptor_iter_if.slave  bus,
    output logic                 busy
);

    typedef logic [6:0] cnt_t;

`ifdef TEA_ENC_UNROLL2_EN
    localparam cnt_t STEP = cnt_t'(2);
`else
    localparam cnt_t STEP = cnt_t'(1);
`endif
    localparam cnt_t LAST = cnt_t'(ROUNDS) - STEP;

    state_e      state_q, state_d;
    word_t       v0_q, v0_d;
    word_t       v1_q, v1_d;
    word_t       sum_q, sum_d;
    cnt_t        cnt_q, cnt_d;
    key_t        key_q, key_d;
    logic [63:0] res_q, res_d;
    logic        armed_q, armed_d;

    word_t r0V0, r0V1, r0Sum;
    word_t nxtV0, nxtV1, nxtSum;
    logic  inReady;

    tea_enc_round #(.DELTA(DELTA)) u_round0 (
        .v0_i  (v0_q),
        .v1_i  (v1_q),
        .sum_i (sum_q),
        .key_i (key_q),
        .v0_o  (r0V0),
        .v1_o  (r0V1),
        .sum_o (r0Sum)
    );

`ifdef TEA_ENC_UNROLL2_EN
    word_t r1V0, r1V1, r1Sum;

    tea_enc_round #(.DELTA(DELTA)) u_round1 (
        .v0_i  (r0V0),
        .v1_i  (r0V1),
        .sum_i (r0Sum),
        .key_i (key_q),
        .v0_o  (r1V0),
        .v1_o  (r1V1),
        .sum_o (r1Sum)
    );

    assign nxtV0  = r1V0;
    assign nxtV1  = r1V1;
    assign nxtSum = r1Sum;

    if (ROUNDS % 2 != 0) begin : g_odd_rounds
        $error("tea_encryptor_iter: ROUNDS must be even when unrolled by two");
    end
`else
    assign nxtV0  = r0V0;
    assign nxtV1  = r0V1;
    assign nxtSum = r0Sum;
`endif

    // in_ready stays low after reset until the first enabled clock edge
    assign inReady        = ena && armed_q && (state_q == IDLE);
    assign bus.in_ready   = inReady;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.outBlock64 = res_q;
    assign busy           = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        res_d   = res_q;
        armed_d = armed_q;
        if (ena) begin
            armed_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && inReady) begin
                        v0_d    = bus.inBlock64[63:32];
                        v1_d    = bus.inBlock64[31:0];
                        key_d   = key_t'(bus.key);
                        sum_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    v0_d  = nxtV0;
                    v1_d  = nxtV1;
                    sum_d = nxtSum;
                    cnt_d = cnt_q + STEP;
                    if (cnt_q == LAST) begin
                        res_d   = {nxtV0, nxtV1};
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            res_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            res_q   <= res_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_tea_encryptor_iter.sv
// Directed bench for tea_encryptor_iter: vector table plus handshake,
// stall, reset and input-change sequences. Honours TEA_ENC_UNROLL2_EN.
module tb_tea_encryptor_iter;

    localparam int ROUNDS = 32;
`ifdef TEA_ENC_UNROLL2_EN
    localparam int LAT = ROUNDS / 2;
`else
    localparam int LAT = ROUNDS;
`endif
    localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;

    typedef struct {
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[5];

    tea_encryptor_iter_if bus ();

    tea_encryptor_iter #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Straight port of the C reference encryptor
    function automatic logic [63:0] teaRef(logic [127:0] k, logic [63:0] pt);
        logic [31:0] y = pt[63:32];
        logic [31:0] z = pt[31:0];
        logic [31:0] s = 32'h0;
        for (int i = 0; i < ROUNDS; i++) begin
            s = s + 32'h9E3779B9;
            y = y + ((((z << 4) + k[127:96]) ^ (z + s)) ^ ((z >> 5) + k[95:64]));
            z = z + ((((y << 4) + k[63:32]) ^ (y + s)) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] k, input logic [63:0] pt);
        int n = 0;
        bus.key       = k;
        bus.inBlock64 = pt;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input bit toggle, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            #1;
            if (toggle) begin
                bus.key       = {$urandom, $urandom, $urandom, $urandom};
                bus.inBlock64 = {$urandom, $urandom};
                bus.in_valid  = 1'($urandom_range(0, 1));
            end
        end while (!bus.out_valid && cycles < 300);
        bus.in_valid = 1'b0;
    endtask

    task automatic finishBlock(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({name, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int c;
        logic [63:0] held;

        vecs[0] = '{key: 128'h0, pt: 64'h0, exp: ZERO_CT};
        vecs[1] = '{key: 128'h01234567_89ABCDEF_FEDCBA98_76543210, pt: 64'h01234567_89ABCDEF, exp: 64'h0};
        vecs[2] = '{key: {128{1'b1}}, pt: {64{1'b1}}, exp: 64'h0};
        vecs[3] = '{key: 128'h00000001_00000000_80000000_00000000, pt: 64'h80000000_00000001, exp: 64'h0};
        vecs[4] = '{key: 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0, pt: 64'h00C0FFEE_BADC0DE5, exp: 64'h0};
        for (int i = 1; i < 5; i++) vecs[i].exp = teaRef(vecs[i].key, vecs[i].pt);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.key       = '0;
        bus.inBlock64 = '0;
        ena           = 1'b1;

        // Reset values, then in_ready held low until the first enabled edge
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_outBlock", bus.outBlock64, 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        #3 rst_n = 1'b1;
        #1;
        checkOutput("pre_edge_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("post_edge_in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].key, vecs[i].pt);
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            waitDone(1'b0, c);
            checkOutput($sformatf("vec%0d_latency", i), 64'(c), 64'(LAT));
            checkOutput($sformatf("vec%0d_ct", i), bus.outBlock64, vecs[i].exp);
            checkOutput($sformatf("vec%0d_in_ready_done", i), 64'(bus.in_ready), 64'd0);
            finishBlock($sformatf("vec%0d", i));
        end

        // Backpressure, then in_valid and out_ready together in DONE
        applyStimulus(vecs[1].key, vecs[1].pt);
        waitDone(1'b0, c);
        held = bus.outBlock64;
        checkOutput("bp_ct", held, vecs[1].exp);
        bus.key       = vecs[2].key;
        bus.inBlock64 = vecs[2].pt;
        bus.in_valid  = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold", {63'd0, bus.out_valid} ^ bus.outBlock64 ^ held,
                        64'd1 ^ held ^ held);
            checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("sim_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("sim_not_accepted", 64'(busy), 64'd0);
        checkOutput("sim_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("sim_accept_next", 64'(busy), 64'd1);
        c = 0;
        while (!bus.out_valid && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("sim_ct", bus.outBlock64, vecs[2].exp);
        finishBlock("sim");

        // ena stall mid-RUN, then an out_ready pulse under ena=0 in DONE
        applyStimulus(128'h0, 64'h0);
        repeat (10) @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_busy", 64'(busy), 64'd1);
        checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
        ena = 1'b1;
        waitDone(1'b0, c);
        checkOutput("stall_latency", 64'(15 + c), 64'(LAT + 5));
        checkOutput("stall_ct", bus.outBlock64, ZERO_CT);
        ena = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        ena = 1'b1;
        checkOutput("ena_low_not_consumed", 64'(bus.out_valid), 64'd1);
        finishBlock("stall");

        // Asynchronous reset mid-RUN aborts everything
        applyStimulus(vecs[4].key, vecs[4].pt);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_outBlock", bus.outBlock64, 64'd0);
        #3 rst_n = 1'b1;
        applyStimulus(vecs[3].key, vecs[3].pt);
        waitDone(1'b0, c);
        checkOutput("post_rst_latency", 64'(c), 64'(LAT));
        checkOutput("post_rst_ct", bus.outBlock64, vecs[3].exp);
        finishBlock("post_rst");

        // Inputs scrambled every clock while the block is in flight
        applyStimulus(vecs[1].key, vecs[1].pt);
        waitDone(1'b1, c);
        checkOutput("toggle_latency", 64'(c), 64'(LAT));
        checkOutput("toggle_ct", bus.outBlock64, vecs[1].exp);
        finishBlock("toggle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
